// File: rtl/mips_cpu_bus_pkg.sv
// Shared types and constants for the mips_cpu_bus arbiter slice.
//   arb_state_t  : arbiter FSM state (IDLE, XFER_I, XFER_D)
//   requester_t  : which requester owns / last owned the bus
//   FETCH_BYTEEN : byte enables driven for every instruction fetch
package mips_cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_I = 2'd1,
        XFER_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    localparam logic [3:0] FETCH_BYTEEN = 4'b1111;

endpackage

// File: rtl/mips_cpu_wait_timer.sv
// Wait-state counter for one bus transfer.
//   clk, rst : clock and synchronous active-high reset
//   clear    : zero the count (asserted on every grant)
//   enable   : count one stalled cycle
//   expired  : count has reached TIMEOUT_CYCLES (never set when TIMEOUT_CYCLES == 0)
module mips_cpu_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned WIDTH   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WIDTH-1:0] LIMIT = WIDTH'(TIMEOUT_CYCLES);
    localparam bit ENABLED = (TIMEOUT_CYCLES != 0);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             at_limit;

    assign at_limit = ENABLED && (count_q == LIMIT);
    assign expired  = at_limit;

    // Saturates at the limit so a timed-out count cannot wrap before the abort edge.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !at_limit) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mips_cpu_bus_arbiter.sv
// Arbitrates the single Avalon-MM master between instruction fetch (I) and
// data load/store (D), one transfer at a time.
//   i_req_* / d_req_* : requests; valid is held until the combinational ready
//                       strobe is seen high (transfer accepted on that edge)
//   i_rsp_* / d_rsp_* : one-cycle completion pulse, rdata, err (timeout abort)
//   address, read, write, writedata, byteenable, waitrequest, readdata : Avalon
//   busy       : state != IDLE
//   bus_error  : sticky timeout flag, cleared only by rst
//   state_dbg  : current FSM state for observation
// Handshake: a request transfers on a clock edge where valid && ready are both 1;
// ready is only ever 1 in IDLE and for at most one requester.
module mips_cpu_bus_arbiter
    import mips_cpu_bus_pkg::*;
#(
    parameter int unsigned PRIORITY_DATA  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req_valid,
    input  logic [31:0] i_req_addr,
    output logic        i_req_ready,
    output logic        i_rsp_valid,
    output logic [31:0] i_rsp_rdata,
    output logic        i_rsp_err,
    input  logic        d_req_valid,
    input  logic        d_req_write,
    input  logic [31:0] d_req_addr,
    input  logic [31:0] d_req_wdata,
    input  logic [3:0]  d_req_byteen,
    output logic        d_req_ready,
    output logic        d_rsp_valid,
    output logic [31:0] d_rsp_rdata,
    output logic        d_rsp_err,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic        waitrequest,
    input  logic [31:0] readdata,
    output logic        busy,
    output logic        bus_error,
    output logic [1:0]  state_dbg
);

    localparam bit D_WINS_TIE = (PRIORITY_DATA != 0);

    arb_state_t  state_q, state_d;
    requester_t  last_grant_q, last_grant_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] writedata_q, writedata_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic        i_rsp_valid_q, i_rsp_valid_d;
    logic [31:0] i_rsp_rdata_q, i_rsp_rdata_d;
    logic        i_rsp_err_q, i_rsp_err_d;
    logic        d_rsp_valid_q, d_rsp_valid_d;
    logic [31:0] d_rsp_rdata_q, d_rsp_rdata_d;
    logic        d_rsp_err_q, d_rsp_err_d;
    logic        bus_error_q, bus_error_d;

    logic grant_i, grant_d;
    logic timer_expired;

    // I wins only when D is absent, or on a round-robin tie when D went last.
    assign grant_i = (state_q == IDLE) && i_req_valid &&
                     (!d_req_valid || (!D_WINS_TIE && last_grant_q == REQ_D));
    assign grant_d = (state_q == IDLE) && d_req_valid && !grant_i;

    assign i_req_ready = grant_i;
    assign d_req_ready = grant_d;

    mips_cpu_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (grant_i || grant_d),
        .enable  ((state_q != IDLE) && waitrequest),
        .expired (timer_expired)
    );

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        address_d     = address_q;
        read_d        = read_q;
        write_d       = write_q;
        writedata_d   = writedata_q;
        byteenable_d  = byteenable_q;
        i_rsp_valid_d = 1'b0;
        i_rsp_rdata_d = i_rsp_rdata_q;
        i_rsp_err_d   = 1'b0;
        d_rsp_valid_d = 1'b0;
        d_rsp_rdata_d = d_rsp_rdata_q;
        d_rsp_err_d   = 1'b0;
        bus_error_d   = bus_error_q;

        case (state_q)
            IDLE: begin
                if (grant_d) begin
                    address_d    = d_req_addr;
                    writedata_d  = d_req_wdata;
                    byteenable_d = d_req_byteen;
                    read_d       = !d_req_write;
                    write_d      = d_req_write;
                    last_grant_d = REQ_D;
                    state_d      = XFER_D;
                end else if (grant_i) begin
                    address_d    = i_req_addr;
                    writedata_d  = 32'h0;
                    byteenable_d = FETCH_BYTEEN;
                    read_d       = 1'b1;
                    write_d      = 1'b0;
                    last_grant_d = REQ_I;
                    state_d      = XFER_I;
                end
            end
            XFER_I, XFER_D: begin
                if (!waitrequest || timer_expired) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = IDLE;
                    if (state_q == XFER_I) begin
                        i_rsp_valid_d = 1'b1;
                        i_rsp_err_d   = waitrequest;
                        i_rsp_rdata_d = waitrequest ? 32'h0 : readdata;
                    end else begin
                        d_rsp_valid_d = 1'b1;
                        d_rsp_err_d   = waitrequest;
                        // Stores return zero; only a completed load carries readdata.
                        d_rsp_rdata_d = (waitrequest || !read_q) ? 32'h0 : readdata;
                    end
                    if (waitrequest) begin
                        bus_error_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            last_grant_q  <= REQ_D;
            address_q     <= 32'h0;
            read_q        <= 1'b0;
            write_q       <= 1'b0;
            writedata_q   <= 32'h0;
            byteenable_q  <= 4'h0;
            i_rsp_valid_q <= 1'b0;
            i_rsp_rdata_q <= 32'h0;
            i_rsp_err_q   <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            d_rsp_rdata_q <= 32'h0;
            d_rsp_err_q   <= 1'b0;
            bus_error_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            address_q     <= address_d;
            read_q        <= read_d;
            write_q       <= write_d;
            writedata_q   <= writedata_d;
            byteenable_q  <= byteenable_d;
            i_rsp_valid_q <= i_rsp_valid_d;
            i_rsp_rdata_q <= i_rsp_rdata_d;
            i_rsp_err_q   <= i_rsp_err_d;
            d_rsp_valid_q <= d_rsp_valid_d;
            d_rsp_rdata_q <= d_rsp_rdata_d;
            d_rsp_err_q   <= d_rsp_err_d;
            bus_error_q   <= bus_error_d;
        end
    end

    assign address     = address_q;
    assign read        = read_q;
    assign write       = write_q;
    assign writedata   = writedata_q;
    assign byteenable  = byteenable_q;
    assign i_rsp_valid = i_rsp_valid_q;
    assign i_rsp_rdata = i_rsp_rdata_q;
    assign i_rsp_err   = i_rsp_err_q;
    assign d_rsp_valid = d_rsp_valid_q;
    assign d_rsp_rdata = d_rsp_rdata_q;
    assign d_rsp_err   = d_rsp_err_q;
    assign bus_error   = bus_error_q;
    assign busy        = (state_q != IDLE);
    assign state_dbg   = state_q;

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter. Instance a: PRIORITY_DATA=1,
// instance b: PRIORITY_DATA=0, both with TIMEOUT_CYCLES=8 and shared inputs.
module tb_mips_cpu_bus_arbiter;
    import mips_cpu_bus_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        i_req_valid, d_req_valid, d_req_write, waitrequest;
    logic [31:0] i_req_addr, d_req_addr, d_req_wdata, readdata;
    logic [3:0]  d_req_byteen;

    logic        a_i_req_ready, a_i_rsp_valid, a_i_rsp_err, a_d_req_ready, a_d_rsp_valid, a_d_rsp_err;
    logic [31:0] a_i_rsp_rdata, a_d_rsp_rdata, a_address, a_writedata;
    logic        a_read, a_write, a_busy, a_bus_error;
    logic [3:0]  a_byteenable;
    logic [1:0]  a_state_dbg;

    logic        b_i_req_ready, b_i_rsp_valid, b_i_rsp_err, b_d_req_ready, b_d_rsp_valid, b_d_rsp_err;
    logic [31:0] b_i_rsp_rdata, b_d_rsp_rdata, b_address, b_writedata;
    logic        b_read, b_write, b_busy, b_bus_error;
    logic [3:0]  b_byteenable;
    logic [1:0]  b_state_dbg;

    int errors = 0;
    int checks = 0;

    mips_cpu_bus_arbiter #(.PRIORITY_DATA(1), .TIMEOUT_CYCLES(8)) dut_a (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(a_i_req_ready),
        .i_rsp_valid(a_i_rsp_valid), .i_rsp_rdata(a_i_rsp_rdata), .i_rsp_err(a_i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_byteen(d_req_byteen), .d_req_ready(a_d_req_ready),
        .d_rsp_valid(a_d_rsp_valid), .d_rsp_rdata(a_d_rsp_rdata), .d_rsp_err(a_d_rsp_err),
        .address(a_address), .read(a_read), .write(a_write), .writedata(a_writedata),
        .byteenable(a_byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .busy(a_busy), .bus_error(a_bus_error), .state_dbg(a_state_dbg)
    );

    mips_cpu_bus_arbiter #(.PRIORITY_DATA(0), .TIMEOUT_CYCLES(8)) dut_b (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_addr(i_req_addr), .i_req_ready(b_i_req_ready),
        .i_rsp_valid(b_i_rsp_valid), .i_rsp_rdata(b_i_rsp_rdata), .i_rsp_err(b_i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_write(d_req_write), .d_req_addr(d_req_addr),
        .d_req_wdata(d_req_wdata), .d_req_byteen(d_req_byteen), .d_req_ready(b_d_req_ready),
        .d_rsp_valid(b_d_rsp_valid), .d_rsp_rdata(b_d_rsp_rdata), .d_rsp_err(b_d_rsp_err),
        .address(b_address), .read(b_read), .write(b_write), .writedata(b_writedata),
        .byteenable(b_byteenable), .waitrequest(waitrequest), .readdata(readdata),
        .busy(b_busy), .bus_error(b_bus_error), .state_dbg(b_state_dbg)
    );

    // Advance to 1 time unit after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        i_req_valid  = 1'b0;
        i_req_addr   = 32'h0;
        d_req_valid  = 1'b0;
        d_req_write  = 1'b0;
        d_req_addr   = 32'h0;
        d_req_wdata  = 32'h0;
        d_req_byteen = 4'h0;
        waitrequest  = 1'b0;
        readdata     = 32'h0;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                                input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    task automatic test_reset;
        do_reset();
        checks++;
        if ({a_read, a_write, a_busy, a_bus_error, a_i_rsp_valid, a_i_rsp_err, a_d_rsp_valid, a_d_rsp_err} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000000",
                     {a_read, a_write, a_busy, a_bus_error, a_i_rsp_valid, a_i_rsp_err, a_d_rsp_valid, a_d_rsp_err});
        end
        checks++;
        if ({a_address, a_writedata, a_byteenable} !== 68'h0) begin
            errors++;
            $display("FAIL reset_bus: got %h/%h/%h expected 0/0/0", a_address, a_writedata, a_byteenable);
        end
        checks++;
        if ({a_i_rsp_rdata, a_d_rsp_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h/%h expected 0/0", a_i_rsp_rdata, a_d_rsp_rdata);
        end
        checks++;
        if (a_state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", a_state_dbg);
        end
    endtask

    task automatic test_fetch;
        do_reset();
        i_req_valid = 1'b1;
        i_req_addr  = 32'hBFC0_0000;
        #1;
        checks++;
        if ({a_i_req_ready, a_d_req_ready} !== 2'b10) begin
            errors++;
            $display("FAIL fetch_ready: got %b expected 10", {a_i_req_ready, a_d_req_ready});
        end
        tick();
        i_req_valid = 1'b0;
        waitrequest = 1'b0;
        readdata    = 32'h2402_0005;
        checks++;
        if ({a_read, a_write, a_busy, a_i_rsp_valid} !== 4'b1010) begin
            errors++;
            $display("FAIL fetch_cycle1_ctrl: got %b expected 1010", {a_read, a_write, a_busy, a_i_rsp_valid});
        end
        checks++;
        if ({a_address, a_byteenable} !== {32'hBFC0_0000, 4'hF}) begin
            errors++;
            $display("FAIL fetch_cycle1_bus: got %h/%h expected bfc00000/f", a_address, a_byteenable);
        end
        tick();
        readdata = 32'h0;
        checks++;
        if ({a_i_rsp_valid, a_i_rsp_err, a_read, a_busy, a_d_rsp_valid} !== 5'b10000) begin
            errors++;
            $display("FAIL fetch_cycle2_ctrl: got %b expected 10000",
                     {a_i_rsp_valid, a_i_rsp_err, a_read, a_busy, a_d_rsp_valid});
        end
        checks++;
        if (a_i_rsp_rdata !== 32'h2402_0005) begin
            errors++;
            $display("FAIL fetch_rdata: got %h expected 24020005", a_i_rsp_rdata);
        end
        tick();
        checks++;
        if (a_i_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL fetch_pulse_width: got %b expected 0", a_i_rsp_valid);
        end
    endtask

    task automatic test_store_wait;
        int pulses;
        do_reset();
        d_req_valid  = 1'b1;
        d_req_write  = 1'b1;
        d_req_addr   = 32'h0000_1000;
        d_req_wdata  = 32'hDEAD_BEEF;
        d_req_byteen = 4'b0011;
        tick();
        d_req_valid = 1'b0;
        // Three stalled cycles then completion: bus held for 4 cycles.
        for (int k = 0; k < 4; k++) begin
            waitrequest = (k < 3);
            checks++;
            if ({a_write, a_read, a_address, a_writedata, a_byteenable, a_d_rsp_valid} !==
                {1'b1, 1'b0, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b0}) begin
                errors++;
                $display("FAIL store_hold_%0d: got w%b r%b %h %h %h v%b expected w1 r0 00001000 deadbeef 3 v0",
                         k, a_write, a_read, a_address, a_writedata, a_byteenable, a_d_rsp_valid);
            end
            tick();
        end
        waitrequest = 1'b0;
        checks++;
        if ({a_d_rsp_valid, a_d_rsp_err, a_write, a_d_rsp_rdata} !== {3'b100, 32'h0}) begin
            errors++;
            $display("FAIL store_rsp: got v%b e%b w%b rdata %h expected v1 e0 w0 rdata 0",
                     a_d_rsp_valid, a_d_rsp_err, a_write, a_d_rsp_rdata);
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_d_rsp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL store_extra_rsp: got %0d expected 0", pulses);
        end
    endtask

    task automatic test_priority_data;
        int    d_left = 3;
        int    i_left = 1;
        int    budget = 0;
        string order  = "";
        do_reset();
        while ((d_left > 0 || i_left > 0) && budget < 100) begin
            i_req_valid = (i_left > 0);
            i_req_addr  = 32'h0000_0100;
            d_req_valid = (d_left > 0);
            d_req_write = 1'b0;
            d_req_addr  = 32'h0000_0200;
            #1;
            if (d_req_valid && a_d_req_ready) begin
                order = {order, "D"};
                d_left--;
            end else if (i_req_valid && a_i_req_ready) begin
                order = {order, "I"};
                i_left--;
            end
            tick();
            budget++;
        end
        idle_inputs();
        checks++;
        if (order != "DDDI") begin
            errors++;
            $display("FAIL priority_order: got %s expected DDDI", order);
        end
    endtask

    task automatic test_round_robin;
        int    d_left = 2;
        int    i_left = 2;
        int    budget = 0;
        string order  = "";
        do_reset();
        while ((d_left > 0 || i_left > 0) && budget < 100) begin
            i_req_valid = (i_left > 0);
            i_req_addr  = 32'h0000_0100;
            d_req_valid = (d_left > 0);
            d_req_write = 1'b0;
            d_req_addr  = 32'h0000_0200;
            #1;
            if (d_req_valid && b_d_req_ready) begin
                order = {order, "D"};
                d_left--;
            end else if (i_req_valid && b_i_req_ready) begin
                order = {order, "I"};
                i_left--;
            end
            tick();
            budget++;
        end
        idle_inputs();
        checks++;
        if (order != "IDID") begin
            errors++;
            $display("FAIL round_robin_order: got %s expected IDID", order);
        end
    endtask

    task automatic test_timeout;
        int n;
        do_reset();
        // A normal fetch first so the aborted response must actively clear rdata.
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0010;
        tick();
        i_req_valid = 1'b0;
        readdata    = 32'h1234_5678;
        tick();
        checks++;
        if (a_i_rsp_rdata !== 32'h1234_5678) begin
            errors++;
            $display("FAIL timeout_pre_rdata: got %h expected 12345678", a_i_rsp_rdata);
        end
        i_req_valid = 1'b1;
        i_req_addr  = 32'h0000_0040;
        waitrequest = 1'b1;
        readdata    = 32'hAAAA_5555;
        tick();
        i_req_valid = 1'b0;
        n = 0;
        while (a_read && n < 40) begin
            n++;
            tick();
        end
        // 8 counted stall edges, abort on the following stalled edge: read high 9 cycles.
        checks++;
        if (n !== 9) begin
            errors++;
            $display("FAIL timeout_read_cycles: got %0d expected 9", n);
        end
        checks++;
        if ({a_i_rsp_valid, a_i_rsp_err, a_bus_error, a_busy} !== 4'b1110) begin
            errors++;
            $display("FAIL timeout_flags: got %b expected 1110", {a_i_rsp_valid, a_i_rsp_err, a_bus_error, a_busy});
        end
        checks++;
        if (a_i_rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL timeout_rdata: got %h expected 0", a_i_rsp_rdata);
        end
        waitrequest = 1'b0;
        tick();
        tick();
        i_req_valid = 1'b1;
        tick();
        i_req_valid = 1'b0;
        readdata    = 32'h1111_1111;
        tick();
        checks++;
        if ({a_i_rsp_valid, a_i_rsp_err, a_bus_error, a_i_rsp_rdata} !== {3'b101, 32'h1111_1111}) begin
            errors++;
            $display("FAIL timeout_after_fetch: got v%b e%b be%b %h expected v1 e0 be1 11111111",
                     a_i_rsp_valid, a_i_rsp_err, a_bus_error, a_i_rsp_rdata);
        end
        do_reset();
        checks++;
        if (a_bus_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_bus_error_reset: got %b expected 0", a_bus_error);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        do_reset();
        d_req_valid = 1'b1;
        d_req_write = 1'b0;
        d_req_addr  = 32'h0000_2000;
        waitrequest = 1'b1;
        tick();
        d_req_valid = 1'b0;
        tick();
        checks++;
        if ({a_read, a_busy} !== 2'b11) begin
            errors++;
            $display("FAIL reset_mid_pre: got %b expected 11", {a_read, a_busy});
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        waitrequest = 1'b0;
        checks++;
        if ({a_read, a_write, a_busy, a_d_rsp_valid} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_abort: got %b expected 0000", {a_read, a_write, a_busy, a_d_rsp_valid});
        end
        pulses = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (a_d_rsp_valid) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL reset_mid_no_rsp: got %0d expected 0", pulses);
        end
        i_req_valid = 1'b1;
        i_req_addr  = 32'hBFC0_0004;
        #1;
        checks++;
        if (a_i_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_ready: got %b expected 1", a_i_req_ready);
        end
        tick();
        i_req_valid = 1'b0;
        readdata    = 32'h8C82_0000;
        tick();
        checks++;
        if ({a_i_rsp_valid, a_i_rsp_err, a_i_rsp_rdata} !== {2'b10, 32'h8C82_0000}) begin
            errors++;
            $display("FAIL reset_mid_fetch: got v%b e%b %h expected v1 e0 8c820000",
                     a_i_rsp_valid, a_i_rsp_err, a_i_rsp_rdata);
        end
    endtask

    task automatic test_random;
        logic [31:0] bus_mem [16];
        logic [31:0] ref_mem [16];
        logic [31:0] exp_i_q [$];
        logic [31:0] exp_d_q [$];
        logic [31:0] e;
        int issued = 0;
        int done   = 0;
        int stall  = 0;
        int cyc    = 0;
        int overlap = 0;
        logic i_pend = 1'b0;
        logic d_pend = 1'b0;
        do_reset();
        for (int k = 0; k < 16; k++) begin
            bus_mem[k] = (32'(k) * 32'h0101_0101) ^ 32'hA5A5_0000;
            ref_mem[k] = bus_mem[k];
        end
        while (done < 1000 && cyc < 30000) begin
            if (a_i_rsp_valid) begin
                done++;
                checks++;
                if (exp_i_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_i_unexpected: got rdata %h expected no response", a_i_rsp_rdata);
                end else begin
                    e = exp_i_q.pop_front();
                    if ({a_i_rsp_err, a_i_rsp_rdata} !== {1'b0, e}) begin
                        errors++;
                        $display("FAIL random_i_rsp: got e%b %h expected e0 %h", a_i_rsp_err, a_i_rsp_rdata, e);
                    end
                end
            end
            if (a_d_rsp_valid) begin
                done++;
                checks++;
                if (exp_d_q.size() == 0) begin
                    errors++;
                    $display("FAIL random_d_unexpected: got rdata %h expected no response", a_d_rsp_rdata);
                end else begin
                    e = exp_d_q.pop_front();
                    if ({a_d_rsp_err, a_d_rsp_rdata} !== {1'b0, e}) begin
                        errors++;
                        $display("FAIL random_d_rsp: got e%b %h expected e0 %h", a_d_rsp_err, a_d_rsp_rdata, e);
                    end
                end
            end
            if (a_read && a_write) overlap++;
            // Slave: random stalls, capped well below the timeout.
            waitrequest = ($urandom_range(0, 2) == 0) && (stall < 4);
            if ((a_read || a_write) && waitrequest) stall++;
            else stall = 0;
            readdata = a_read ? bus_mem[a_address[5:2]] : $urandom;
            if (a_write && !waitrequest)
                bus_mem[a_address[5:2]] = merge_bytes(bus_mem[a_address[5:2]], a_writedata, a_byteenable);
            // Requesters.
            if (!i_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
                i_pend = 1'b1;
                issued++;
                i_req_addr = 32'h1FC0_0000 | (32'($urandom_range(0, 15)) << 2);
            end
            if (!d_pend && issued < 1000 && $urandom_range(0, 1) == 1) begin
                d_pend = 1'b1;
                issued++;
                d_req_write  = ($urandom_range(0, 1) == 1);
                d_req_addr   = 32'h0000_8000 | (32'($urandom_range(0, 15)) << 2);
                d_req_wdata  = $urandom;
                d_req_byteen = 4'($urandom_range(0, 15));
            end
            i_req_valid = i_pend;
            d_req_valid = d_pend;
            #1;
            if (i_pend && a_i_req_ready) begin
                exp_i_q.push_back(ref_mem[i_req_addr[5:2]]);
                i_pend = 1'b0;
            end
            if (d_pend && a_d_req_ready) begin
                if (d_req_write) begin
                    ref_mem[d_req_addr[5:2]] = merge_bytes(ref_mem[d_req_addr[5:2]], d_req_wdata, d_req_byteen);
                    exp_d_q.push_back(32'h0);
                end else begin
                    exp_d_q.push_back(ref_mem[d_req_addr[5:2]]);
                end
                d_pend = 1'b0;
            end
            tick();
            cyc++;
        end
        idle_inputs();
        checks++;
        if (done !== 1000) begin
            errors++;
            $display("FAIL random_completion: got %0d responses in %0d cycles expected 1000", done, cyc);
        end
        checks++;
        if (exp_i_q.size() + exp_d_q.size() != 0) begin
            errors++;
            $display("FAIL random_leftover: got %0d outstanding expected 0", exp_i_q.size() + exp_d_q.size());
        end
        checks++;
        if (overlap !== 0) begin
            errors++;
            $display("FAIL random_rw_overlap: got %0d cycles expected 0", overlap);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_fetch();
        test_store_wait();
        test_priority_data();
        test_round_robin();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
